// File: rtl/adc_spi_streamer.sv
// Periodic SPI ADC reader that packs each conversion frame into a word and streams it through a FWFT FIFO.
// Optional build macro ADC_STREAM_TEST_PATTERN_EN replaces the ADC data with a per-frame ramp counter.
module adc_spi_streamer #(
    parameter int ADC_WIDTH     = 12,
    parameter int SCLK_DIV      = 4,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    output logic                 adc_cs_n,
    output logic                 adc_sclk,
    input  logic                 adc_miso,
    output logic                 stream_valid_out,
    input  logic                 stream_ready_in,
    output logic [ADC_WIDTH-1:0] stream_data_out,
    output logic                 overflow
);

    localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W = (ADC_WIDTH > 1) ? $clog2(ADC_WIDTH) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(ADC_WIDTH - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_PUSH
    } state_t;

    // ------------------------------------------------------------------
    // Sample tick counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    assign tick = enable && (tick_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (enable) begin
            tick_cnt <= (tick_cnt == CNT_LAST) ? '0 : tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // SPI frame FSM
    // ------------------------------------------------------------------
    state_t           state, state_next;
    logic [DIV_W-1:0] div_cnt, div_next;
    logic [BIT_W-1:0] bit_cnt, bit_next;
    logic             sclk_next;
    logic             cs_active_next;
    logic             sample_bit;
    logic             div_done;

    assign div_done = (div_cnt == DIV_LAST);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next     = state;
        div_next       = div_cnt;
        bit_next       = bit_cnt;
        sclk_next      = 1'b0;
        sample_bit     = 1'b0;
        cs_active_next = 1'b0;

        case (state)
            S_IDLE: begin
                div_next = '0;
                bit_next = '0;
                if (tick) state_next = S_SETUP;
            end
            S_SETUP: begin
                if (div_done) begin
                    state_next = S_SHIFT;
                    div_next   = '0;
                    sclk_next  = 1'b1;
                    sample_bit = 1'b1;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            S_SHIFT: begin
                sclk_next = adc_sclk;
                if (div_done) begin
                    div_next = '0;
                    if (adc_sclk) begin
                        // The low half of the final bit period is the HOLD phase.
                        sclk_next = 1'b0;
                        if (bit_cnt == BIT_LAST) state_next = S_HOLD;
                        else                     bit_next   = bit_cnt + 1'b1;
                    end else begin
                        sclk_next  = 1'b1;
                        sample_bit = 1'b1;
                    end
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (div_done) begin
                    state_next = S_PUSH;
                    div_next   = '0;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            S_PUSH: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        cs_active_next = (state_next == S_SETUP) || (state_next == S_SHIFT) ||
                         (state_next == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            adc_sclk <= 1'b0;
            adc_cs_n <= 1'b1;
        end else begin
            state    <= state_next;
            div_cnt  <= div_next;
            bit_cnt  <= bit_next;
            adc_sclk <= sclk_next;
            adc_cs_n <= !cs_active_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame word source
    // ------------------------------------------------------------------
    logic [ADC_WIDTH-1:0] frame_word;

`ifdef ADC_STREAM_TEST_PATTERN_EN
    logic [ADC_WIDTH-1:0] ramp;
    logic                 unused_miso;
    logic                 unused_sample;

    assign unused_miso   = adc_miso;
    assign unused_sample = sample_bit;
    assign frame_word    = ramp;

    always_ff @(posedge clk) begin
        if (rst) begin
            ramp <= '0;
        end else if (state == S_PUSH) begin
            ramp <= ramp + 1'b1;
        end
    end
`else
    logic [ADC_WIDTH-1:0] shift_reg;

    assign frame_word = shift_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
        end else if (sample_bit) begin
            shift_reg <= {shift_reg[ADC_WIDTH-2:0], adc_miso};
        end
    end
`endif

    // ------------------------------------------------------------------
    // First-word fall-through stream FIFO
    // ------------------------------------------------------------------
    logic [ADC_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PTR_W:0]       fifo_count, count_next;
    logic                 push_req, push, pop, full;

    assign full     = (fifo_count == FIFO_FULL);
    assign pop      = stream_valid_out && stream_ready_in;
    assign push_req = (state == S_PUSH);
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign push     = push_req && (!full || pop);

    always_comb begin
        count_next = fifo_count;
        if (push && !pop)      count_next = fifo_count + 1'b1;
        else if (!push && pop) count_next = fifo_count - 1'b1;
    end

    // NOTE: storage array is deliberately not reset; only pointers/flags are, and the output is masked while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= frame_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            fifo_count       <= '0;
            stream_valid_out <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count       <= count_next;
            stream_valid_out <= (count_next != '0);
            if (push_req && !push) overflow <= 1'b1;
        end
    end

    assign stream_data_out = stream_valid_out ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_adc_spi_streamer.sv
// Directed bench for adc_spi_streamer: frame timing, backpressure, full+pop, enable gating, mid-frame reset.
module tb_adc_spi_streamer;

    localparam int W  = 12;
    localparam int SD = 4;
    localparam int P  = 1000;
    localparam int D  = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         adc_miso = 1'b0;
    logic         stream_ready_in = 1'b0;
    logic         adc_cs_n;
    logic         adc_sclk;
    logic         stream_valid_out;
    logic [W-1:0] stream_data_out;
    logic         overflow;

    int vectors     = 0;
    int miscompares = 0;

    adc_spi_streamer #(
        .ADC_WIDTH    (W),
        .SCLK_DIV     (SD),
        .SAMPLE_PERIOD(P),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .adc_cs_n        (adc_cs_n),
        .adc_sclk        (adc_sclk),
        .adc_miso        (adc_miso),
        .stream_valid_out(stream_valid_out),
        .stream_ready_in (stream_ready_in),
        .stream_data_out (stream_data_out),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    // ADC model: MSB presented when cs_n falls, next bit after each falling sclk.
    logic [W-1:0] miso_word = '0;
    int           bit_idx   = 0;
    int           rise_cnt  = 0;
    logic         prev_cs_n = 1'b1;
    logic         prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (adc_cs_n === 1'b0 && prev_cs_n === 1'b1) begin
            bit_idx  = W - 1;
            adc_miso = miso_word[bit_idx];
        end else if (adc_cs_n === 1'b0 && adc_sclk === 1'b0 && prev_sclk === 1'b1 && bit_idx > 0) begin
            bit_idx  = bit_idx - 1;
            adc_miso = miso_word[bit_idx];
        end
        if (adc_sclk === 1'b1 && prev_sclk === 1'b0) rise_cnt++;
        prev_cs_n = adc_cs_n;
        prev_sclk = adc_sclk;
    end

    task automatic do_reset();
        rst             = 1'b1;
        enable          = 1'b0;
        stream_ready_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns at the negedge of the PUSH cycle (first cycle with cs_n high again).
    task automatic wait_push(input string name, output int wait_cycles, output int low_cycles,
                             output int rises);
        int r0;
        wait_cycles = 0;
        low_cycles  = 0;
        rises       = 0;
        while (adc_cs_n !== 1'b0 && wait_cycles < 3 * P) begin
            @(negedge clk);
            wait_cycles++;
        end
        vectors++;
        if (adc_cs_n !== 1'b0) begin
            miscompares++;
            $display("FAIL %s cs_n_fall: no frame start within %0d cycles", name, 3 * P);
            return;
        end
        r0 = rise_cnt;
        while (adc_cs_n === 1'b0 && low_cycles < 400) begin
            @(negedge clk);
            low_cycles++;
        end
        rises = rise_cnt - r0;
        vectors++;
        if (adc_cs_n !== 1'b1) begin
            miscompares++;
            $display("FAIL %s cs_n_rise: cs_n still %b after %0d cycles", name, adc_cs_n, low_cycles);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors += 5;
        if (adc_cs_n !== 1'b1) begin
            miscompares++; $display("FAIL reset_cs_n: observed %b expected 1", adc_cs_n);
        end
        if (adc_sclk !== 1'b0) begin
            miscompares++; $display("FAIL reset_sclk: observed %b expected 0", adc_sclk);
        end
        if (stream_valid_out !== 1'b0) begin
            miscompares++; $display("FAIL reset_valid: observed %b expected 0", stream_valid_out);
        end
        if (stream_data_out !== '0) begin
            miscompares++; $display("FAIL reset_data: observed %h expected 000", stream_data_out);
        end
        if (overflow !== 1'b0) begin
            miscompares++; $display("FAIL reset_overflow: observed %b expected 0", overflow);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        int wc, lc, rc;
        do_reset();
        miso_word = 12'hA5C;
        enable    = 1'b1;
        wait_push("single", wc, lc, rc);
        vectors += 4;
        if (wc !== 1000) begin
            miscompares++; $display("FAIL single_tick_latency: observed %0d expected 1000", wc);
        end
        if (lc !== 100) begin
            miscompares++; $display("FAIL single_cs_low: observed %0d expected 100", lc);
        end
        if (rc !== 12) begin
            miscompares++; $display("FAIL single_sclk_rises: observed %0d expected 12", rc);
        end
        if (stream_valid_out !== 1'b0) begin
            miscompares++; $display("FAIL single_valid_early: observed %b expected 0", stream_valid_out);
        end
        @(negedge clk);
        vectors += 3;
        if (stream_valid_out !== 1'b1) begin
            miscompares++; $display("FAIL single_valid: observed %b expected 1", stream_valid_out);
        end
        if (stream_data_out !== 12'hA5C) begin
            miscompares++; $display("FAIL single_data: observed %h expected a5c", stream_data_out);
        end
        if (overflow !== 1'b0) begin
            miscompares++; $display("FAIL single_overflow: observed %b expected 0", overflow);
        end
        stream_ready_in = 1'b1;
        @(negedge clk);
        stream_ready_in = 1'b0;
        vectors++;
        if (stream_valid_out !== 1'b0) begin
            miscompares++; $display("FAIL single_pop_empty: observed %b expected 0", stream_valid_out);
        end
        enable = 1'b0;
    endtask

    task automatic test_backpressure();
        int wc, lc, rc;
        do_reset();
        enable = 1'b1;
        for (int f = 1; f <= 8; f++) begin
            miso_word = W'(f);
            wait_push("bp_fill", wc, lc, rc);
        end
        @(negedge clk);
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++; $display("FAIL bp_overflow_at_8: observed %b expected 0", overflow);
        end
        miso_word = W'(9);
        wait_push("bp_ninth", wc, lc, rc);
        @(negedge clk);
        vectors += 2;
        if (overflow !== 1'b1) begin
            miscompares++; $display("FAIL bp_overflow_at_9: observed %b expected 1", overflow);
        end
        if (stream_data_out !== W'(1)) begin
            miscompares++; $display("FAIL bp_head: observed %h expected 001", stream_data_out);
        end
        stream_ready_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            vectors++;
            if (stream_valid_out !== 1'b1 || stream_data_out !== W'(i)) begin
                miscompares++;
                $display("FAIL bp_drain_%0d: observed valid=%b data=%h expected valid=1 data=%h",
                         i, stream_valid_out, stream_data_out, W'(i));
            end
            @(negedge clk);
        end
        stream_ready_in = 1'b0;
        vectors += 2;
        if (stream_valid_out !== 1'b0) begin
            miscompares++; $display("FAIL bp_empty: observed %b expected 0", stream_valid_out);
        end
        if (overflow !== 1'b1) begin
            miscompares++; $display("FAIL bp_sticky: observed %b expected 1", overflow);
        end
        enable = 1'b0;
    endtask

    task automatic test_full_pop();
        int wc, lc, rc;
        do_reset();
        enable = 1'b1;
        for (int f = 1; f <= 8; f++) begin
            miso_word = W'(f);
            wait_push("fp_fill", wc, lc, rc);
        end
        miso_word = W'(9);
        wait_push("fp_ninth", wc, lc, rc);
        stream_ready_in = 1'b1;
        @(negedge clk);
        stream_ready_in = 1'b0;
        vectors += 3;
        if (overflow !== 1'b0) begin
            miscompares++; $display("FAIL fp_overflow: observed %b expected 0", overflow);
        end
        if (stream_valid_out !== 1'b1) begin
            miscompares++; $display("FAIL fp_valid: observed %b expected 1", stream_valid_out);
        end
        if (stream_data_out !== W'(2)) begin
            miscompares++; $display("FAIL fp_head: observed %h expected 002", stream_data_out);
        end
        stream_ready_in = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            vectors++;
            if (stream_valid_out !== 1'b1 || stream_data_out !== W'(i)) begin
                miscompares++;
                $display("FAIL fp_drain_%0d: observed valid=%b data=%h expected valid=1 data=%h",
                         i, stream_valid_out, stream_data_out, W'(i));
            end
            @(negedge clk);
        end
        stream_ready_in = 1'b0;
        vectors++;
        if (stream_valid_out !== 1'b0) begin
            miscompares++; $display("FAIL fp_empty: observed %b expected 0", stream_valid_out);
        end
        enable = 1'b0;
    endtask

    task automatic test_enable_gating();
        int   n;
        int   falls;
        logic prev;
        do_reset();
        miso_word = 12'h3C7;
        enable    = 1'b1;
        n = 0;
        while (adc_cs_n !== 1'b0 && n < 3 * P) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        enable = 1'b0;
        n = 0;
        while (adc_cs_n !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        vectors += 2;
        if (stream_valid_out !== 1'b1) begin
            miscompares++; $display("FAIL gate_valid: observed %b expected 1", stream_valid_out);
        end
        if (stream_data_out !== 12'h3C7) begin
            miscompares++; $display("FAIL gate_data: observed %h expected 3c7", stream_data_out);
        end
        falls = 0;
        prev  = adc_cs_n;
        for (int c = 0; c < 3 * P; c++) begin
            @(negedge clk);
            if (prev === 1'b1 && adc_cs_n === 1'b0) falls++;
            prev = adc_cs_n;
        end
        vectors++;
        if (falls !== 0) begin
            miscompares++; $display("FAIL gate_no_frames: observed %0d cs_n falls expected 0", falls);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        do_reset();
        miso_word = 12'hFFF;
        enable    = 1'b1;
        n = 0;
        while (adc_cs_n !== 1'b0 && n < 3 * P) begin
            @(negedge clk);
            n++;
        end
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors += 4;
        if (adc_cs_n !== 1'b1) begin
            miscompares++; $display("FAIL midrst_cs_n: observed %b expected 1", adc_cs_n);
        end
        if (adc_sclk !== 1'b0) begin
            miscompares++; $display("FAIL midrst_sclk: observed %b expected 0", adc_sclk);
        end
        if (stream_valid_out !== 1'b0) begin
            miscompares++; $display("FAIL midrst_valid: observed %b expected 0", stream_valid_out);
        end
        if (overflow !== 1'b0) begin
            miscompares++; $display("FAIL midrst_overflow: observed %b expected 0", overflow);
        end
        rst    = 1'b0;
        enable = 1'b0;
        repeat (200) @(negedge clk);
        vectors += 2;
        if (stream_valid_out !== 1'b0) begin
            miscompares++; $display("FAIL midrst_no_push: observed valid=%b expected 0", stream_valid_out);
        end
        if (adc_cs_n !== 1'b1) begin
            miscompares++; $display("FAIL midrst_idle: observed cs_n=%b expected 1", adc_cs_n);
        end
    endtask

`ifdef ADC_STREAM_TEST_PATTERN_EN
    task automatic test_pattern();
        int wc, lc, rc;
        do_reset();
        miso_word = '1;
        enable    = 1'b1;
        for (int f = 0; f < 5; f++) wait_push("pattern", wc, lc, rc);
        @(negedge clk);
        stream_ready_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (stream_valid_out !== 1'b1 || stream_data_out !== W'(i)) begin
                miscompares++;
                $display("FAIL pattern_%0d: observed valid=%b data=%h expected valid=1 data=%h",
                         i, stream_valid_out, stream_data_out, W'(i));
            end
            @(negedge clk);
        end
        stream_ready_in = 1'b0;
        enable          = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
`ifdef ADC_STREAM_TEST_PATTERN_EN
        test_pattern();
`else
        test_single_frame();
        test_backpressure();
        test_full_pop();
        test_enable_gating();
`endif
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
